// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the multicycle RISC-V core.
// Owns the PC, fetches words over a req/ack handshake into a holding buffer,
// and transfers the buffer into the instruction register on LoadIR.
module fetch_unit #(
    parameter int unsigned         PC_W     = 64,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            PCWriteCond,
    input  logic            PCSrc,
    input  logic            BranchOp,
    input  logic            Zero,
    input  logic [PC_W-1:0] ALUResult,
    input  logic [PC_W-1:0] ALUOut,
    input  logic            LoadIR,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] PC,
    output logic [31:0]     instruction,
    output logic            ir_valid,
    output logic            fetch_busy,
    output logic            fetch_fault,
    output logic            ir_underflow
);

    typedef enum logic [1:0] {
        START,
        REQ,
        READY,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [31:0]     buf_q, buf_d;
    logic            stale_q, stale_d;
    logic [31:0]     instr_q, instr_d;
    logic            ir_valid_q, ir_valid_d;
    logic            ir_underflow_q, ir_underflow_d;
    logic            imem_req_q, imem_req_d;
    logic            fetch_busy_q, fetch_busy_d;
    logic            fetch_fault_q, fetch_fault_d;

    logic            pc_load;
    logic [PC_W-1:0] new_pc;
    logic            load_ok;
    logic            target_ok;

    // Next-state logic: PC update, fetch FSM, IR transfer and status flags
    always_comb begin
        pc_load   = PCWrite | (PCWriteCond & (Zero ^ BranchOp));
        new_pc    = PCSrc ? ALUOut : ALUResult;
        load_ok   = LoadIR && (state_q == READY);

        pc_d           = pc_load ? new_pc : pc_q;
        target_ok      = (pc_d[1:0] == 2'b00);
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        buf_d          = buf_q;
        stale_d        = stale_q;
        instr_d        = load_ok ? buf_q : instr_q;
        ir_underflow_d = ir_underflow_q | (LoadIR && (state_q != READY));

        if (pc_load) begin
            ir_valid_d = 1'b0;
        end else if (load_ok) begin
            ir_valid_d = 1'b1;
        end else begin
            ir_valid_d = ir_valid_q;
        end

        // Fetch targets use pc_d so a PC write in the launching cycle
        // is never fetched from the old address.
        unique case (state_q)
            START: begin
                if (target_ok) begin
                    state_d      = REQ;
                    fetch_addr_d = pc_d;
                end else begin
                    state_d = FAULT;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (stale_q || pc_load) begin
                        stale_d = 1'b0;
                        if (target_ok) begin
                            state_d      = REQ;
                            fetch_addr_d = pc_d;
                        end else begin
                            state_d = FAULT;
                        end
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = READY;
                    end
                end else if (pc_load) begin
                    stale_d = 1'b1;
                end
            end
            READY: begin
                if (pc_load) begin
                    if (target_ok) begin
                        state_d      = REQ;
                        fetch_addr_d = pc_d;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                if (pc_load && target_ok) begin
                    state_d      = REQ;
                    fetch_addr_d = pc_d;
                end
            end
            default: state_d = START;
        endcase

        imem_req_d    = (state_d == REQ);
        fetch_busy_d  = (state_d != READY);
        fetch_fault_d = (state_d == FAULT);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= START;
            pc_q           <= RESET_PC;
            fetch_addr_q   <= RESET_PC;
            buf_q          <= '0;
            stale_q        <= 1'b0;
            instr_q        <= '0;
            ir_valid_q     <= 1'b0;
            ir_underflow_q <= 1'b0;
            imem_req_q     <= 1'b0;
            fetch_busy_q   <= 1'b1;
            fetch_fault_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_addr_q   <= fetch_addr_d;
            buf_q          <= buf_d;
            stale_q        <= stale_d;
            instr_q        <= instr_d;
            ir_valid_q     <= ir_valid_d;
            ir_underflow_q <= ir_underflow_d;
            imem_req_q     <= imem_req_d;
            fetch_busy_q   <= fetch_busy_d;
            fetch_fault_q  <= fetch_fault_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = fetch_addr_q;
    assign PC           = pc_q;
    assign instruction  = instr_q;
    assign ir_valid     = ir_valid_q;
    assign fetch_busy   = fetch_busy_q;
    assign fetch_fault  = fetch_fault_q;
    assign ir_underflow = ir_underflow_q;

endmodule
